// File: rtl/arbitro_rr_salida_pkg.sv
// Shared definitions for the weighted round-robin output scheduler:
// word field positions, class count and weight normalization.
package arbitro_rr_salida_pkg;

   localparam int NUM_CLASSES   = 4;
   localparam int NUM_DESTS     = 4;
   localparam int SEL_W         = 2;
   localparam int WORD_SIZE_DEF = 12;

   // Field positions for the default 12-bit word; wider words shift them up.
   localparam int CLASS_MSB = 11;
   localparam int CLASS_LSB = 10;
   localparam int DEST_MSB  = 9;
   localparam int DEST_LSB  = 8;

   localparam int WEIGHT_MAX_W = 8;

   function automatic logic [WEIGHT_MAX_W-1:0] norm_weight(input logic [WEIGHT_MAX_W-1:0] w);
      return (w == '0) ? WEIGHT_MAX_W'(1) : w;
   endfunction

endpackage

// File: rtl/arbitro_rr_salida_rr_next_sel.sv
// Circular priority scan: first non-empty class after cur, wrapping
// around so that cur itself is the last candidate.
module rr_next_sel
   import arbitro_rr_salida_pkg::*;
(
   input  logic [SEL_W-1:0]       cur_i,
   input  logic [NUM_CLASSES-1:0] mask_i,
   output logic [SEL_W-1:0]       next_o,
   output logic                   found_o
);

   logic [SEL_W-1:0]       cand [NUM_CLASSES];
   logic [NUM_CLASSES-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_cand
         assign cand[gi] = cur_i + SEL_W'(gi + 1);
         assign hit[gi]  = mask_i[cand[gi]];
      end
   endgenerate

   // Walk from the farthest candidate back so the nearest hit wins.
   always_comb begin
      next_o  = cur_i;
      found_o = 1'b0;
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            next_o  = cand[i];
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_rr_salida.sv
// Weighted round-robin scheduler draining four class FIFOs onto four
// destination FIFOs, with a one-stage in-flight pipe and backpressure.
module arbitro_rr_salida
   import arbitro_rr_salida_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int WEIGHT_W  = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CLASSES*WORD_SIZE-1:0] data_in,
   input  logic [NUM_CLASSES-1:0]           fifo_empty,
   input  logic [NUM_CLASSES*WEIGHT_W-1:0]  weight,
   input  logic [NUM_DESTS-1:0]             dest_almost_full,
   output logic [NUM_CLASSES-1:0]           pop,
   output logic [NUM_DESTS-1:0]             push,
   output logic [WORD_SIZE-1:0]             data_out,
   output logic [SEL_W-1:0]                 grant_class,
   output logic                             idle
);

   localparam int DEST_HI = DEST_MSB + WORD_SIZE - WORD_SIZE_DEF;
   localparam int DEST_LO = DEST_LSB + WORD_SIZE - WORD_SIZE_DEF;

   logic [SEL_W-1:0]       cur_q, cur_d;
   logic [WEIGHT_W-1:0]    credit_q, credit_d;
   logic                   v1_q, v1_d;
   logic [SEL_W-1:0]       c1_q, c1_d;
   logic [NUM_DESTS-1:0]   push_q, push_d;
   logic [WORD_SIZE-1:0]   data_out_q, data_out_d;

   logic [NUM_CLASSES-1:0] pop_c;
   logic                   stall;
   logic                   found;
   logic [SEL_W-1:0]       next_idx;
   logic [WORD_SIZE-1:0]   word_arr   [NUM_CLASSES];
   logic [WEIGHT_W-1:0]    weight_arr [NUM_CLASSES];
   logic [WORD_SIZE-1:0]   word_sel;
   logic [WEIGHT_W-1:0]    weight_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
         assign word_arr[gi]   = data_in[gi*WORD_SIZE +: WORD_SIZE];
         assign weight_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
      end
   endgenerate

   assign stall       = |dest_almost_full;
   assign word_sel    = word_arr[c1_q];
   assign weight_next = weight_arr[next_idx];

   rr_next_sel u_next_sel (
      .cur_i   (cur_q),
      .mask_i  (~fifo_empty),
      .next_o  (next_idx),
      .found_o (found)
   );

   // Pop and turn switch are exclusive: a switch only happens when no pop is possible.
   always_comb begin
      pop_c    = '0;
      cur_d    = cur_q;
      credit_d = credit_q;
      if (!stall) begin
         if ((credit_q != '0) && !fifo_empty[cur_q]) begin
            pop_c[cur_q] = 1'b1;
            credit_d     = credit_q - WEIGHT_W'(1);
         end else if (found) begin
            cur_d    = next_idx;
            credit_d = WEIGHT_W'(norm_weight(WEIGHT_MAX_W'(weight_next)));
         end
      end
   end

   assign v1_d = |pop_c;
   assign c1_d = cur_q;

   always_comb begin
      push_d     = '0;
      data_out_d = '0;
      if (v1_q) begin
         data_out_d = word_sel;
         push_d     = NUM_DESTS'(1) << word_sel[DEST_HI:DEST_LO];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cur_q      <= SEL_W'(NUM_CLASSES - 1);
         credit_q   <= '0;
         v1_q       <= 1'b0;
         c1_q       <= '0;
         push_q     <= '0;
         data_out_q <= '0;
      end else begin
         cur_q      <= cur_d;
         credit_q   <= credit_d;
         v1_q       <= v1_d;
         c1_q       <= c1_d;
         push_q     <= push_d;
         data_out_q <= data_out_d;
      end
   end

   // Gating pop during reset keeps the class FIFOs from losing a word.
   assign pop         = reset ? pop_c : '0;
   assign push        = push_q;
   assign data_out    = data_out_q;
   assign grant_class = cur_q;
   assign idle        = ~(|pop) & ~v1_q;

endmodule
